// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - request, register-file write and forwarding signals of writeback_queue
interface writeback_queue_if #(
   parameter int REG_COUNT = 32,
   parameter int REG_W     = 32,
   parameter int DEPTH     = 4,
   parameter int REG_IDX_W = $clog2(REG_COUNT),
   parameter int CNT_W     = $clog2(DEPTH + 1)
);
   logic                 mem_valid;
   logic                 mem_ready;
   logic [REG_IDX_W-1:0] mem_reg;
   logic [REG_W-1:0]     mem_data;
   logic                 alu_valid;
   logic                 alu_ready;
   logic [REG_IDX_W-1:0] alu_reg;
   logic [REG_W-1:0]     alu_data;
   logic                 wr_en;
   logic [REG_IDX_W-1:0] wr_reg;
   logic [REG_W-1:0]     wr_data;
   logic [REG_IDX_W-1:0] fwd_reg_a;
   logic [REG_IDX_W-1:0] fwd_reg_b;
   logic                 fwd_hit_a;
   logic                 fwd_hit_b;
   logic [REG_W-1:0]     fwd_data_a;
   logic [REG_W-1:0]     fwd_data_b;
   logic [CNT_W-1:0]     count;

   modport slave (
      input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, fwd_reg_a, fwd_reg_b,
      output mem_ready, alu_ready, wr_en, wr_reg, wr_data, fwd_hit_a, fwd_hit_b, fwd_data_a,
             fwd_data_b, count
   );

   modport master (
      output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, fwd_reg_a, fwd_reg_b,
      input  mem_ready, alu_ready, wr_en, wr_reg, wr_data, fwd_hit_a, fwd_hit_b, fwd_data_a,
             fwd_data_b, count
   );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order register write-back FIFO with one-write-per-cycle drain and forwarding
module writeback_queue #(
   parameter int REG_COUNT = 32,
   parameter int REG_W     = 32,
   parameter int REG_IDX_W = $clog2(REG_COUNT),
   parameter int DEPTH     = 4
) (
   input  logic           clk,
   input  logic           aresetn,
   writeback_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [REG_IDX_W-1:0] q_reg  [DEPTH];
   logic [REG_W-1:0]     q_data [DEPTH];
   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [PTR_W-1:0]     alu_slot;
   logic [CNT_W-1:0]     count;
   logic                 mem_push;
   logic                 alu_push;
   logic                 pop;
   logic                 wr_en_q;
   logic [REG_IDX_W-1:0] wr_reg_q;
   logic [REG_W-1:0]     wr_data_q;
   logic                 hit_a;
   logic                 hit_b;
   logic [REG_W-1:0]     data_a;
   logic [REG_W-1:0]     data_b;
   logic [PTR_W-1:0]     slot;

   // Readiness looks only at the pre-edge count, so a same-edge pop never frees space early.
   assign bus.mem_ready = aresetn && (count <= CNT_W'(DEPTH - 1));
   assign bus.alu_ready = aresetn && (count <= CNT_W'(DEPTH - 2));

   // Writes to r0 complete the handshake but are dropped here.
   assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_reg != '0);
   assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_reg != '0);
   assign pop      = (count != '0);
   assign alu_slot = tail + PTR_W'(mem_push);

   always_ff @(posedge clk) begin
      if (mem_push) begin
         q_reg[tail]  <= bus.mem_reg;
         q_data[tail] <= bus.mem_data;
      end
      if (alu_push) begin
         q_reg[alu_slot]  <= bus.alu_reg;
         q_data[alu_slot] <= bus.alu_data;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= pop;
         if (pop) begin
            wr_reg_q  <= q_reg[head];
            wr_data_q <= q_data[head];
            head      <= head + PTR_W'(1);
         end
         tail  <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
         count <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
      end
   end

   // Scan oldest to youngest so later matches overwrite earlier ones; the output stage is oldest of all.
   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      data_a = '0;
      data_b = '0;
      slot   = head;
      if (wr_en_q && (wr_reg_q == bus.fwd_reg_a)) begin
         hit_a  = 1'b1;
         data_a = wr_data_q;
      end
      if (wr_en_q && (wr_reg_q == bus.fwd_reg_b)) begin
         hit_b  = 1'b1;
         data_b = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PTR_W'(i);
         if (CNT_W'(i) < count) begin
            if (q_reg[slot] == bus.fwd_reg_a) begin
               hit_a  = 1'b1;
               data_a = q_data[slot];
            end
            if (q_reg[slot] == bus.fwd_reg_b) begin
               hit_b  = 1'b1;
               data_b = q_data[slot];
            end
         end
      end
   end

   assign bus.fwd_hit_a  = hit_a && (bus.fwd_reg_a != '0);
   assign bus.fwd_hit_b  = hit_b && (bus.fwd_reg_b != '0);
   assign bus.fwd_data_a = bus.fwd_hit_a ? data_a : '0;
   assign bus.fwd_data_b = bus.fwd_hit_b ? data_b : '0;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_reg     = wr_reg_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.count      = count;
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue against a queue-based model
module tb_writeback_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   writeback_queue_if #(.REG_COUNT(32), .REG_W(32), .DEPTH(DEPTH)) bus ();

   writeback_queue #(.REG_COUNT(32), .REG_W(32), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Model: pending writes in arrival order plus the single register-file output stage.
   ent_t mq[$];
   logic m_wen;
   ent_t m_out;
   ent_t acc_list[$];
   bit   last_macc, last_aacc;

   task automatic model_reset();
      mq.delete();
      m_wen = 1'b0;
      m_out = '0;
   endtask

   function automatic void model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (r == 5'd0) return;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].r == r) begin
            hit = 1'b1;
            d   = mq[i].d;
            return;
         end
      end
      if (m_wen && m_out.r == r) begin
         hit = 1'b1;
         d   = m_out.d;
      end
   endfunction

   task automatic step(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
      int n;
      bus.mem_valid = mv;
      bus.mem_reg   = mr;
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_reg   = ar;
      bus.alu_data  = ad;
      n = mq.size();
      last_macc = mv && (n <= DEPTH - 1);
      last_aacc = av && (n <= DEPTH - 2);
      @(posedge clk);
      if (n > 0) begin
         m_out = mq.pop_front();
         m_wen = 1'b1;
      end else begin
         m_wen = 1'b0;
      end
      if (last_macc && mr != 5'd0) begin
         mq.push_back({mr, md});
         acc_list.push_back({mr, md});
      end
      if (last_aacc && ar != 5'd0) begin
         mq.push_back({ar, ad});
         acc_list.push_back({ar, ad});
      end
      @(negedge clk);
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
      bus.mem_reg = '0; bus.mem_data = '0; bus.alu_reg = '0; bus.alu_data = '0;
      bus.fwd_reg_a = 5'd5; bus.fwd_reg_b = 5'd0;
      model_reset();
      @(negedge clk);
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", bus.wr_en); end
      checks++; if (bus.wr_reg !== 5'd0) begin errors++; $display("FAIL reset_wr_reg got %0d exp 0", bus.wr_reg); end
      checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", bus.wr_data); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 00", bus.mem_ready, bus.alu_ready); end
      checks++; if (bus.fwd_hit_a !== 1'b0 || bus.fwd_data_a !== 32'd0) begin errors++; $display("FAIL reset_fwd got %0b/%h exp 0/0", bus.fwd_hit_a, bus.fwd_data_a); end
      aresetn = 1'b1;
      #1;
      checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b%0b exp 11", bus.mem_ready, bus.alu_ready); end
      checks++; if (bus.fwd_hit_a !== 1'b0) begin errors++; $display("FAIL release_fwd got %0b exp 0", bus.fwd_hit_a); end
   endtask

   task automatic test_single();
      bus.fwd_reg_a = 5'd5;
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      checks++; if (bus.count !== 3'd1 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_e1 got count %0d wr_en %0b exp 1 0", bus.count, bus.wr_en); end
      checks++; if (bus.fwd_hit_a !== 1'b1 || bus.fwd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_e1 got %0b/%h exp 1/deadbeef", bus.fwd_hit_a, bus.fwd_data_a); end
      idle();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_reg !== 5'd5 || bus.wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write got %0b %0d %h exp 1 5 deadbeef", bus.wr_en, bus.wr_reg, bus.wr_data); end
      checks++; if (bus.fwd_hit_a !== 1'b1 || bus.fwd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_e2 got %0b/%h exp 1/deadbeef", bus.fwd_hit_a, bus.fwd_data_a); end
      idle();
      checks++; if (bus.wr_en !== 1'b0 || bus.wr_reg !== 5'd5 || bus.wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_e3 got %0b %0d %h exp 0 5 deadbeef", bus.wr_en, bus.wr_reg, bus.wr_data); end
      checks++; if (bus.fwd_hit_a !== 1'b0 || bus.fwd_data_a !== 32'd0) begin errors++; $display("FAIL single_fwd_e3 got %0b/%h exp 0/0", bus.fwd_hit_a, bus.fwd_data_a); end
   endtask

   task automatic test_simultaneous();
      bus.fwd_reg_a = 5'd3;
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
      checks++; if (bus.count !== 3'd2 || bus.fwd_data_a !== 32'h22) begin errors++; $display("FAIL simul_e1 got count %0d fwd %h exp 2 22", bus.count, bus.fwd_data_a); end
      idle();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h11 || bus.fwd_data_a !== 32'h22) begin errors++; $display("FAIL simul_e2 got %0b %h fwd %h exp 1 11 22", bus.wr_en, bus.wr_data, bus.fwd_data_a); end
      idle();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h22 || bus.fwd_data_a !== 32'h22) begin errors++; $display("FAIL simul_e3 got %0b %h fwd %h exp 1 22 22", bus.wr_en, bus.wr_data, bus.fwd_data_a); end
      idle();
      checks++; if (bus.wr_en !== 1'b0 || bus.fwd_hit_a !== 1'b0) begin errors++; $display("FAIL simul_e4 got %0b %0b exp 0 0", bus.wr_en, bus.fwd_hit_a); end
   endtask

   task automatic test_reg_zero();
      bus.fwd_reg_b = 5'd0;
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFFFF;
      #1;
      checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", bus.alu_ready); end
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
      checks++; if (bus.count !== 3'd0 || bus.fwd_hit_b !== 1'b0) begin errors++; $display("FAIL r0_e1 got count %0d hit %0b exp 0 0", bus.count, bus.fwd_hit_b); end
      idle();
      checks++; if (bus.wr_en !== 1'b0 || bus.fwd_hit_b !== 1'b0) begin errors++; $display("FAIL r0_e2 got wr_en %0b hit %0b exp 0 0", bus.wr_en, bus.fwd_hit_b); end
   endtask

   task automatic test_wrap();
      ent_t got[$];
      for (int i = 0; i < 12; i++) begin
         if (i < 10) step(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i) * 32'h111, 1'b0, 5'd0, 32'd0);
         else idle();
         if (bus.wr_en === 1'b1) got.push_back({bus.wr_reg, bus.wr_data});
      end
      checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_len got %0d exp 10", got.size()); end
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         checks++;
         if (got[i].r !== 5'(i + 1) || got[i].d !== 32'hA000_0000 + 32'(i) * 32'h111) begin
            errors++; $display("FAIL wrap_entry%0d got %0d/%h exp %0d/%h", i, got[i].r, got[i].d, i + 1, 32'hA000_0000 + 32'(i) * 32'h111);
         end
      end
   endtask

   task automatic test_random();
      logic mv, av;
      logic [4:0] mr, ar;
      logic [31:0] md, ad;
      logic eh;
      logic [31:0] ed;
      int issued;
      ent_t dut_w[$];
      mv = 1'b0; av = 1'b0; mr = '0; ar = '0; md = '0; ad = '0;
      issued = 0;
      acc_list.delete();
      for (int cyc = 0; cyc < 200 && (issued < 20 || mv || av || mq.size() > 0 || m_wen); cyc++) begin
         if (!mv && issued < 20) begin mv = 1'b1; mr = 5'($urandom_range(1, 7)); md = $urandom; issued++; end
         if (!av && issued < 20) begin av = 1'b1; ar = 5'($urandom_range(1, 7)); ad = $urandom; issued++; end
         bus.fwd_reg_a = 5'($urandom_range(0, 7));
         bus.fwd_reg_b = 5'($urandom_range(0, 7));
         step(mv, mr, md, av, ar, ad);
         if (last_macc) mv = 1'b0;
         if (last_aacc) av = 1'b0;
         if (bus.wr_en === 1'b1) dut_w.push_back({bus.wr_reg, bus.wr_data});
         checks++; if (bus.count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, bus.count, mq.size()); end
         checks++; if (bus.mem_ready !== (mq.size() <= DEPTH - 1) || bus.alu_ready !== (mq.size() <= DEPTH - 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b%0b count %0d", cyc, bus.mem_ready, bus.alu_ready, mq.size()); end
         checks++; if (bus.wr_en !== m_wen || (m_wen && (bus.wr_reg !== m_out.r || bus.wr_data !== m_out.d))) begin errors++; $display("FAIL rnd_write cyc %0d got %0b %0d %h exp %0b %0d %h", cyc, bus.wr_en, bus.wr_reg, bus.wr_data, m_wen, m_out.r, m_out.d); end
         model_fwd(bus.fwd_reg_a, eh, ed);
         checks++; if (bus.fwd_hit_a !== eh || bus.fwd_data_a !== ed) begin errors++; $display("FAIL rnd_fwd_a cyc %0d reg %0d got %0b/%h exp %0b/%h", cyc, bus.fwd_reg_a, bus.fwd_hit_a, bus.fwd_data_a, eh, ed); end
         model_fwd(bus.fwd_reg_b, eh, ed);
         checks++; if (bus.fwd_hit_b !== eh || bus.fwd_data_b !== ed) begin errors++; $display("FAIL rnd_fwd_b cyc %0d reg %0d got %0b/%h exp %0b/%h", cyc, bus.fwd_reg_b, bus.fwd_hit_b, bus.fwd_data_b, eh, ed); end
      end
      checks++; if (dut_w.size() != 20 || acc_list.size() != 20) begin errors++; $display("FAIL rnd_total got %0d written %0d accepted exp 20", dut_w.size(), acc_list.size()); end
      for (int i = 0; i < dut_w.size() && i < acc_list.size(); i++) begin
         checks++; if (dut_w[i] !== acc_list[i]) begin errors++; $display("FAIL rnd_order%0d got %0d/%h exp %0d/%h", i, dut_w[i].r, dut_w[i].d, acc_list[i].r, acc_list[i].d); end
      end
   endtask

   task automatic test_mid_reset();
      bus.fwd_reg_a = 5'd12;
      step(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'h10);
      step(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12);
      checks++; if (bus.count !== 3'd3 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre got count %0d alu_ready %0b exp 3 0", bus.count, bus.alu_ready); end
      aresetn = 1'b0;
      model_reset();
      #1;
      checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL midrst_state got wr_en %0b count %0d exp 0 0", bus.wr_en, bus.count); end
      checks++; if (bus.fwd_hit_a !== 1'b0 || bus.fwd_hit_b !== 1'b0) begin errors++; $display("FAIL midrst_fwd got %0b%0b exp 00", bus.fwd_hit_a, bus.fwd_hit_b); end
      checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %0b%0b exp 00", bus.mem_ready, bus.alu_ready); end
      @(posedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0 || bus.fwd_hit_a !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d got %0b %0d %0b exp 0 0 0", i, bus.wr_en, bus.count, bus.fwd_hit_a); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_reg_zero();
      test_wrap();
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
